// File: rtl/physics_scheduler_if.sv
// Engine handshake bundle between physics_scheduler (master) and the shared
// physics update engine (slave).
interface physics_scheduler_if #(
  parameter int IDX_W = 2
);
  logic             upd_req;
  logic [IDX_W-1:0] upd_idx;
  logic [10:0]      upd_row_cur;
  logic [11:0]      upd_col_cur;
  logic             upd_ack;
  logic [10:0]      upd_row_new;
  logic [11:0]      upd_col_new;

  modport master (
    output upd_req, upd_idx, upd_row_cur, upd_col_cur,
    input  upd_ack, upd_row_new, upd_col_new
  );

  modport slave (
    input  upd_req, upd_idx, upd_row_cur, upd_col_cur,
    output upd_ack, upd_row_new, upd_col_new
  );
endinterface

// File: rtl/physics_scheduler.sv
// Per-frame sprite update sequencer: walks each sprite through the shared engine,
// gathers results in a shadow buffer and commits them atomically to the live buses.
// Optional macro PHYS_CLAMP_EN clamps engine results and init values to MAX_ROW/MAX_COL.
module physics_scheduler #(
  parameter int SPRITES = 4,
  parameter int MAX_ROW = 1199,
  parameter int MAX_COL = 1599,
  parameter int TIMEOUT = 64,
  localparam int IDX_W  = (SPRITES > 1) ? $clog2(SPRITES) : 1
) (
  input  logic                   clock_162,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   frame_start,
  input  logic                   init_we,
  input  logic [IDX_W-1:0]       init_idx,
  input  logic [10:0]            init_row,
  input  logic [11:0]            init_col,
  physics_scheduler_if.master    upd,
  output logic [SPRITES*11-1:0]  sprite_row,
  output logic [SPRITES*12-1:0]  sprite_col,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   timeout_err,
  input  logic                   err_clear
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

`ifdef PHYS_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [10:0] ROW_LIM = 11'(MAX_ROW);
  localparam logic [11:0] COL_LIM = 12'(MAX_COL);

  function automatic logic [10:0] clamp_row(input logic [10:0] v);
    return (CLAMP_EN && (v > ROW_LIM)) ? ROW_LIM : v;
  endfunction

  function automatic logic [11:0] clamp_col(input logic [11:0] v);
    return (CLAMP_EN && (v > COL_LIM)) ? COL_LIM : v;
  endfunction

  typedef enum logic [1:0] {IDLE, REQ, NEXT, COMMIT} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [10:0]      live_row   [SPRITES];
  logic [11:0]      live_col   [SPRITES];
  logic [10:0]      shadow_row [SPRITES];
  logic [11:0]      shadow_col [SPRITES];
  logic             start, ack_hit, timeout_hit, last;

  assign start       = frame_start && enable;
  assign ack_hit     = (state == REQ) && upd.upd_ack;
  assign timeout_hit = (state == REQ) && !upd.upd_ack && (cnt == CNT_W'(TIMEOUT - 1));
  assign last        = (idx == IDX_W'(SPRITES - 1));
  assign busy        = (state != IDLE);

  // Live values only change in IDLE/COMMIT, so cur stays stable throughout REQ.
  assign upd.upd_req     = (state == REQ);
  assign upd.upd_idx     = idx;
  assign upd.upd_row_cur = live_row[idx];
  assign upd.upd_col_cur = live_col[idx];

  always_ff @(posedge clock_162 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = REQ;
      REQ:     if (ack_hit || timeout_hit) state_n = NEXT;
      NEXT:    state_n = last ? COMMIT : REQ;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_162 or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      cnt         <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && start)      idx <= '0;
      else if (state == NEXT && !last) idx <= idx + IDX_W'(1);

      // Counter is zero everywhere outside REQ, so each REQ entry starts fresh.
      if (state == REQ) cnt <= cnt + CNT_W'(1);
      else              cnt <= '0;

      frame_done <= (state == COMMIT);

      if (start && busy)  overrun <= 1'b1;
      else if (err_clear) overrun <= 1'b0;

      if (timeout_hit)    timeout_err <= 1'b1;
      else if (err_clear) timeout_err <= 1'b0;
    end
  end

  always_ff @(posedge clock_162 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SPRITES; i++) begin
        live_row[i]   <= '0;
        live_col[i]   <= '0;
        shadow_row[i] <= '0;
        shadow_col[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SPRITES; i++) begin
        if (state == IDLE && init_we && init_idx == IDX_W'(i)) begin
          live_row[i]   <= clamp_row(init_row);
          live_col[i]   <= clamp_col(init_col);
          shadow_row[i] <= clamp_row(init_row);
          shadow_col[i] <= clamp_col(init_col);
        end else begin
          if (state == COMMIT) begin
            live_row[i] <= shadow_row[i];
            live_col[i] <= shadow_col[i];
          end
          if (state == REQ && idx == IDX_W'(i)) begin
            if (upd.upd_ack) begin
              shadow_row[i] <= clamp_row(upd.upd_row_new);
              shadow_col[i] <= clamp_col(upd.upd_col_new);
            end else if (timeout_hit) begin
              shadow_row[i] <= live_row[i];
              shadow_col[i] <= live_col[i];
            end
          end
        end
      end
    end
  end

  always_comb begin
    sprite_row = '0;
    sprite_col = '0;
    for (int i = 0; i < SPRITES; i++) begin
      sprite_row[i*11 +: 11] = live_row[i];
      sprite_col[i*12 +: 12] = live_col[i];
    end
  end

endmodule

// File: tb/tb_physics_scheduler.sv
// Directed bench for physics_scheduler: table of init writes, then hand-built
// frame sequences driven against a small behavioural engine.
module tb_physics_scheduler;

  logic        clk = 1'b0;
  logic        rst, enable, frame_start, init_we, err_clear;
  logic [1:0]  init_idx;
  logic [10:0] init_row;
  logic [11:0] init_col;
  logic [43:0] sprite_row;
  logic [47:0] sprite_col;
  logic        busy, frame_done, overrun, timeout_err;

  int errors = 0;
  int checks = 0;

  physics_scheduler_if #(.IDX_W(2)) upd_if ();

  physics_scheduler #(
    .SPRITES(4), .MAX_ROW(1199), .MAX_COL(1599), .TIMEOUT(64)
  ) dut (
    .clock_162  (clk),
    .rst        (rst),
    .enable     (enable),
    .frame_start(frame_start),
    .init_we    (init_we),
    .init_idx   (init_idx),
    .init_row   (init_row),
    .init_col   (init_col),
    .upd        (upd_if),
    .sprite_row (sprite_row),
    .sprite_col (sprite_col),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun),
    .timeout_err(timeout_err),
    .err_clear  (err_clear)
  );

  always #5 clk = ~clk;

  // Engine: acks after delay[idx] REQ cycles with cur+(1,2), or (2047,4000) when big.
  int delay [4];
  bit big;
  int wait_cnt = 0;

  always @(negedge clk) begin
    if (upd_if.upd_req === 1'b1) begin
      if (wait_cnt >= delay[upd_if.upd_idx]) begin
        upd_if.upd_ack = 1'b1;
        if (big) begin
          upd_if.upd_row_new = 11'd2047;
          upd_if.upd_col_new = 12'd4000;
        end else begin
          upd_if.upd_row_new = upd_if.upd_row_cur + 11'd1;
          upd_if.upd_col_new = upd_if.upd_col_cur + 12'd2;
        end
      end else begin
        upd_if.upd_ack = 1'b0;
      end
      wait_cnt++;
    end else begin
      upd_if.upd_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  function automatic logic [43:0] pr(input int r3, input int r2, input int r1, input int r0);
    return {11'(r3), 11'(r2), 11'(r1), 11'(r0)};
  endfunction

  function automatic logic [47:0] pc(input int c3, input int c2, input int c1, input int c0);
    return {12'(c3), 12'(c2), 12'(c1), 12'(c0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int lat, done_cnt, stable_err, early_chg, seq_code, seq_len;
  int req_cyc [4];

  // Pulse frame_start, then observe each cycle (#1 after the edge) until frame_done
  // plus 10 more cycles. second_at >= 1 raises frame_start again at that edge count.
  task automatic run_frame(input int second_at);
    logic [43:0] r0;
    logic [47:0] c0;
    logic        p_req;
    logic [1:0]  p_idx;
    logic [10:0] p_row;
    logic [11:0] p_col;
    lat = -1; done_cnt = 0; stable_err = 0; early_chg = 0; seq_code = 0; seq_len = 0;
    for (int i = 0; i < 4; i++) req_cyc[i] = 0;
    r0 = sprite_row; c0 = sprite_col;
    p_req = 1'b0; p_idx = '0; p_row = '0; p_col = '0;
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (frame_done) begin
        done_cnt++;
        if (lat < 0) lat = n;
      end
      if (lat < 0) begin
        if (sprite_row !== r0 || sprite_col !== c0) early_chg++;
        if (upd_if.upd_req) begin
          req_cyc[upd_if.upd_idx]++;
          if (!p_req) begin
            seq_code = seq_code * 10 + int'(upd_if.upd_idx);
            seq_len++;
          end else if (upd_if.upd_idx !== p_idx || upd_if.upd_row_cur !== p_row ||
                       upd_if.upd_col_cur !== p_col) begin
            stable_err++;
          end
        end
        p_req = upd_if.upd_req; p_idx = upd_if.upd_idx;
        p_row = upd_if.upd_row_cur; p_col = upd_if.upd_col_cur;
      end
      if (lat >= 0 && n >= lat + 10) break;
      frame_start = (n + 1 == second_at);
      @(posedge clk); #1;
    end
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk); err_clear = 1'b1;
    @(posedge clk); #1; err_clear = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  idx;
    logic [10:0] row;
    logic [11:0] col;
    logic [43:0] exp_row;
    logic [47:0] exp_col;
  } init_vec_t;

  init_vec_t tbl [6];

  initial begin
    rst = 1'b1; enable = 1'b1; frame_start = 1'b0; init_we = 1'b0; err_clear = 1'b0;
    init_idx = '0; init_row = '0; init_col = '0; big = 1'b0;
    for (int i = 0; i < 4; i++) delay[i] = 0;

    tbl[0] = '{1'b1, 2'd0, 11'd10,  12'd20,   pr(0, 0, 0, 10),    pc(0, 0, 0, 20)};
    tbl[1] = '{1'b1, 2'd1, 11'd11,  12'd21,   pr(0, 0, 11, 10),   pc(0, 0, 21, 20)};
    tbl[2] = '{1'b1, 2'd3, 11'd13,  12'd23,   pr(13, 0, 11, 10),  pc(23, 0, 21, 20)};
    tbl[3] = '{1'b0, 2'd2, 11'd99,  12'd99,   pr(13, 0, 11, 10),  pc(23, 0, 21, 20)};
    tbl[4] = '{1'b1, 2'd2, 11'd400, 12'd1300, pr(13, 400, 11, 10), pc(23, 1300, 21, 20)};
    tbl[5] = '{1'b1, 2'd0, 11'd5,   12'd6,    pr(13, 400, 11, 5),  pc(23, 1300, 21, 6)};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_row", sprite_row, 0);
    chk("reset_col", sprite_col, 0);
    chk("reset_req", upd_if.upd_req, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", frame_done, 0);
    chk("reset_flags", {overrun, timeout_err}, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      init_we = tbl[i].we; init_idx = tbl[i].idx; init_row = tbl[i].row; init_col = tbl[i].col;
      @(posedge clk); #1; init_we = 1'b0;
      chk($sformatf("init_row[%0d]", i), sprite_row, tbl[i].exp_row);
      chk($sformatf("init_col[%0d]", i), sprite_col, tbl[i].exp_col);
    end

    // Zero-wait engine.
    run_frame(-1);
    chk("a_latency", lat, 9);
    chk("a_idx_seq", seq_code, 123);
    chk("a_idx_len", seq_len, 4);
    chk("a_stable", stable_err, 0);
    chk("a_early_change", early_chg, 0);
    chk("a_done_count", done_cnt, 1);
    chk("a_row", sprite_row, pr(14, 401, 12, 6));
    chk("a_col", sprite_col, pc(25, 1302, 23, 8));
    chk("a_timeout_err", timeout_err, 0);

    // Sprite 1 ack delayed by 3 cycles.
    delay[1] = 3;
    run_frame(-1);
    chk("b_latency", lat, 12);
    chk("b_req_cycles", req_cyc[1], 4);
    chk("b_stable", stable_err, 0);
    chk("b_row", sprite_row, pr(15, 402, 13, 7));
    chk("b_col", sprite_col, pc(27, 1304, 25, 10));

    // Sprite 0 never acked.
    delay[1] = 0; delay[0] = 1000;
    run_frame(-1);
    chk("c_latency", lat, 72);
    chk("c_req_cycles", req_cyc[0], 64);
    chk("c_timeout_err", timeout_err, 1);
    chk("c_row", sprite_row, pr(16, 403, 14, 7));
    chk("c_col", sprite_col, pc(29, 1306, 27, 10));
    pulse_clear();
    chk("c_err_cleared", timeout_err, 0);
    delay[0] = 0;

    // Second frame_start three cycles into the frame.
    run_frame(3);
    chk("d_overrun", overrun, 1);
    chk("d_latency", lat, 9);
    chk("d_done_count", done_cnt, 1);
    chk("d_row", sprite_row, pr(17, 404, 15, 8));
    chk("d_col", sprite_col, pc(31, 1308, 29, 12));

    // err_clear coinciding with a fresh overrun event: set wins.
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
    @(negedge clk); frame_start = 1'b1; err_clear = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0; err_clear = 1'b0;
    chk("d_set_wins", overrun, 1);
    wait_idle("d2_idle");
    chk("d2_row", sprite_row, pr(18, 405, 16, 9));
    pulse_clear();
    chk("d_overrun_cleared", overrun, 0);

    // enable low masks frame_start.
    enable = 1'b0;
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
    chk("en_low_busy", busy, 0);
    chk("en_low_overrun", overrun, 0);
    enable = 1'b1;

    // init_we while busy is ignored.
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
    @(negedge clk); init_we = 1'b1; init_idx = 2'd2; init_row = 11'd1; init_col = 12'd2;
    @(posedge clk); #1; init_we = 1'b0;
    wait_idle("e_idle");
    chk("e_row", sprite_row, pr(19, 406, 17, 10));
    chk("e_col", sprite_col, pc(35, 1312, 33, 16));

    // init_we and frame_start together: first REQ shows the new value.
    @(negedge clk);
    frame_start = 1'b1; init_we = 1'b1; init_idx = 2'd0; init_row = 11'd100; init_col = 12'd200;
    @(posedge clk); #1; frame_start = 1'b0; init_we = 1'b0;
    chk("f_first_req", {upd_if.upd_req, upd_if.upd_idx}, 3'b100);
    chk("f_cur_row", upd_if.upd_row_cur, 100);
    chk("f_cur_col", upd_if.upd_col_cur, 200);
    wait_idle("f_idle");
    chk("f_row", sprite_row, pr(20, 407, 18, 101));
    chk("f_col", sprite_col, pc(37, 1314, 35, 202));

    // Reset in the middle of a frame, with overrun already set.
    delay[1] = 5;
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("g_pre_overrun", overrun, 1);
    chk("g_pre_req", upd_if.upd_req, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("g_rst_row", sprite_row, 0);
    chk("g_rst_col", sprite_col, 0);
    chk("g_rst_req_idx", {upd_if.upd_req, upd_if.upd_idx}, 0);
    chk("g_rst_status", {busy, frame_done, overrun, timeout_err}, 0);
    @(negedge clk); rst = 1'b0;
    delay[1] = 0;
    done_cnt = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (frame_done) done_cnt++;
    end
    chk("g_no_done", done_cnt, 0);

    // Out-of-range engine results and init values.
    big = 1'b1;
    run_frame(-1);
    big = 1'b0;
    chk("h_latency", lat, 9);
`ifdef PHYS_CLAMP_EN
    chk("h_row", sprite_row, pr(1199, 1199, 1199, 1199));
    chk("h_col", sprite_col, pc(1599, 1599, 1599, 1599));
`else
    chk("h_row", sprite_row, pr(2047, 2047, 2047, 2047));
    chk("h_col", sprite_col, pc(4000, 4000, 4000, 4000));
`endif
    @(negedge clk); init_we = 1'b1; init_idx = 2'd1; init_row = 11'd2000; init_col = 12'd4095;
    @(posedge clk); #1; init_we = 1'b0;
`ifdef PHYS_CLAMP_EN
    chk("h_init_row", sprite_row[21:11], 1199);
    chk("h_init_col", sprite_col[23:12], 1599);
`else
    chk("h_init_row", sprite_row[21:11], 2000);
    chk("h_init_col", sprite_col[23:12], 4095);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
